// File: rtl/cu_mi_pkg.sv
// Shared opcodes, ALU function codes, control-word layout and state encoding for control_unit_mi.
// No logic of its own; latency and backpressure are properties of the modules that import it.
// Build with CU_SINGLE_STEP_EN defined to add the WAIT state used for single-step operation.
package cu_mi_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SL   = 4'h7;
    localparam logic [3:0] OP_SR   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_PCST = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_BR   = 4'hD;
    localparam logic [3:0] OP_BCC  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [2:0] FS_AND = 3'b000;
    localparam logic [2:0] FS_OR  = 3'b001;
    localparam logic [2:0] FS_ADD = 3'b010;
    localparam logic [2:0] FS_SUB = 3'b011;
    localparam logic [2:0] FS_SL  = 3'b100;
    localparam logic [2:0] FS_SR  = 3'b101;
    localparam logic [2:0] FS_XOR = 3'b110;

    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_NZ = 2'b01;
    localparam logic [1:0] CC_C  = 2'b10;
    localparam logic [1:0] CC_N  = 2'b11;

    localparam int CW_W     = 22;
    localparam int CW_SL    = 21;
    localparam int CW_IL    = 20;
    localparam int CW_PCL   = 19;
    localparam int CW_MR    = 18;
    localparam int CW_MW    = 17;
    localparam int CW_BSEL  = 16;
    localparam int CW_ASEL  = 15;
    localparam int CW_EN    = 14;
    localparam int CW_CI    = 13;
    localparam int CW_FS    = 10;
    localparam int CW_WR    = 9;
    localparam int CW_SB    = 6;
    localparam int CW_SA    = 3;
    localparam int CW_DA    = 0;

    // Field order matches the datapath's control_word bit layout, MSB first.
    typedef struct packed {
        logic       sl;
        logic       il;
        logic       pcl;
        logic       mr;
        logic       mw;
        logic       b_sel;
        logic       a_sel;
        logic       en_alu;
        logic       ci;
        logic [2:0] fs;
        logic       w;
        logic [2:0] sb;
        logic [2:0] sa;
        logic [2:0] da;
    } cw_t;

    localparam cw_t CW_ZERO  = 22'b0;
    localparam cw_t CW_FETCH = 22'b0_1_1_0_0_0_1_1_1_010_0_111_000_000;

`ifdef CU_SINGLE_STEP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;
`endif

    function automatic logic [2:0] alu_fs(input logic [3:0] op);
        case (op)
            OP_ADD:  alu_fs = FS_ADD;
            OP_SUB:  alu_fs = FS_SUB;
            OP_AND:  alu_fs = FS_AND;
            OP_OR:   alu_fs = FS_OR;
            OP_XOR:  alu_fs = FS_XOR;
            OP_SL:   alu_fs = FS_SL;
            OP_SR:   alu_fs = FS_SR;
            default: alu_fs = FS_AND;
        endcase
    endfunction

    // status bits: [0]=Z, [1]=N, [2]=C; V is not a branch condition.
    function automatic logic cc_taken(input logic [1:0] cc, input logic [2:0] znc);
        case (cc)
            CC_Z:    cc_taken = znc[0];
            CC_NZ:   cc_taken = ~znc[0];
            CC_C:    cc_taken = znc[2];
            default: cc_taken = znc[1];
        endcase
    endfunction

endpackage

// File: rtl/control_unit_mi_if.sv
// Instruction/flag inputs and control-word/immediate outputs between sequencer and datapath_mi.
// Pure wiring, zero latency.
// No backpressure; the datapath consumes one control word every cycle.
interface control_unit_mi_if;
    logic [15:0] I;
    logic [3:0]  alu_status;
    logic [21:0] control_word;
    logic [7:0]  K;

    modport master (
        input  I,
        input  alu_status,
        output control_word,
        output K
    );

    modport slave (
        output I,
        output alu_status,
        input  control_word,
        input  K
    );
endinterface

// File: rtl/cu_mi_decode.sv
// Combinational instruction decoder: (I, alu_status) -> execute-cycle control word and immediate.
// Zero latency, purely combinational.
// No backpressure; outputs follow inputs every cycle.
module cu_mi_decode
    import cu_mi_pkg::*;
(
    input  logic [15:0] I,
    input  logic [3:0]  alu_status,
    output cw_t         exec_word,
    output logic [7:0]  exec_K,
    output logic        is_halt
);

    logic [3:0] op;
    logic       s;
    logic [2:0] f_da;
    logic [2:0] f_sa;
    logic [2:0] f_sb;
    logic [7:0] imm;
    logic       unused_v;

    assign op       = I[15:12];
    assign s        = I[11];
    assign f_da     = I[10:8];
    assign f_sa     = I[7:5];
    assign f_sb     = I[4:2];
    assign imm      = I[7:0];
    assign unused_v = alu_status[3];

    always_comb begin
        exec_word = CW_ZERO;
        exec_K    = 8'h00;
        is_halt   = 1'b0;

        case (op)
            OP_MOVI: begin
                exec_word.b_sel  = 1'b1;
                exec_word.en_alu = 1'b1;
                exec_word.fs     = FS_OR;
                exec_word.w      = 1'b1;
                exec_word.sb     = 3'b000;
                exec_word.sa     = 3'b111;
                exec_word.da     = f_da;
                exec_K           = imm;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SR: begin
                exec_word.sl     = s;
                exec_word.en_alu = 1'b1;
                exec_word.w      = 1'b1;
                exec_word.fs     = alu_fs(op);
                exec_word.ci     = (op == OP_SUB);
                exec_word.sb     = f_sb;
                exec_word.sa     = f_sa;
                exec_word.da     = f_da;
            end
            OP_ST: begin
                // Store address comes from the register named in the DA slot.
                exec_word.mw     = 1'b1;
                exec_word.en_alu = 1'b1;
                exec_word.fs     = FS_OR;
                exec_word.sb     = 3'b111;
                exec_word.sa     = f_da;
                exec_K           = imm;
            end
            OP_LD: begin
                exec_word.mr = 1'b1;
                exec_word.w  = 1'b1;
                exec_word.da = f_da;
                exec_K       = imm;
            end
            OP_PCST: begin
                exec_word.a_sel  = 1'b1;
                exec_word.en_alu = 1'b1;
                exec_word.ci     = 1'b1;
                exec_word.fs     = FS_ADD;
                exec_word.w      = 1'b1;
                exec_word.sb     = 3'b111;
                exec_word.da     = f_da;
            end
            OP_B, OP_BCC: begin
                if (op == OP_B || cc_taken(I[9:8], alu_status[2:0])) begin
                    exec_word.pcl    = 1'b1;
                    exec_word.b_sel  = 1'b1;
                    exec_word.a_sel  = 1'b1;
                    exec_word.en_alu = 1'b1;
                    exec_word.ci     = 1'b1;
                    exec_word.fs     = FS_ADD;
                    exec_K           = imm;
                end
            end
            OP_BR: begin
                exec_word.pcl    = 1'b1;
                exec_word.en_alu = 1'b1;
                exec_word.fs     = FS_OR;
                exec_word.sb     = 3'b111;
                exec_word.sa     = f_sa;
            end
            OP_HLT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit_mi.sv
// Multi-cycle sequencer for datapath_mi: FETCH then EXEC per instruction, HALT until reset.
// Two cycles per instruction (three with CU_SINGLE_STEP_EN and step held high); outputs are combinational.
// No backpressure; CU_SINGLE_STEP_EN adds a WAIT state released by the step input.
module control_unit_mi
    import cu_mi_pkg::*;
#(
    parameter int ICNT_W = 16
)
(
    input  logic              clk,
    input  logic              rst,
`ifdef CU_SINGLE_STEP_EN
    input  logic              step,
`endif
    control_unit_mi_if.master bus,
    output logic              halted,
    output logic [ICNT_W-1:0] icount
);

`ifdef CU_SINGLE_STEP_EN
    localparam state_t ST_RESET     = ST_WAIT;
    localparam state_t ST_POST_EXEC = ST_WAIT;
`else
    localparam state_t ST_RESET     = ST_FETCH;
    localparam state_t ST_POST_EXEC = ST_FETCH;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       retire;
    cw_t        cw;
    logic [7:0] k_val;
    cw_t        exec_word;
    logic [7:0] exec_K;
    logic       is_halt;

    cu_mi_decode u_decode (
        .I          (bus.I),
        .alu_status (bus.alu_status),
        .exec_word  (exec_word),
        .exec_K     (exec_K),
        .is_halt    (is_halt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RESET;
            icount <= '0;
        end else begin
            state <= state_nxt;
            if (retire) begin
                icount <= icount + ICNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        cw        = CW_ZERO;
        k_val     = 8'h00;

        case (state)
            ST_FETCH: begin
                cw        = CW_FETCH;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                cw        = exec_word;
                k_val     = exec_K;
                retire    = 1'b1;
                state_nxt = is_halt ? ST_HALT : ST_POST_EXEC;
            end
            ST_HALT: state_nxt = ST_HALT;
`ifdef CU_SINGLE_STEP_EN
            ST_WAIT: begin
                if (step) begin
                    state_nxt = ST_FETCH;
                end
            end
`endif
            default: state_nxt = ST_RESET;
        endcase
    end

    // Reset forces a quiet datapath even mid-instruction, so no EXEC word leaks out.
    assign bus.control_word = rst ? CW_ZERO : cw;
    assign bus.K            = rst ? 8'h00 : k_val;
    assign halted           = ~rst && (state == ST_HALT);

endmodule
